fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Sequential instruction-fetch controller between the byte-wide instruction memory port and the decode stage. Owns the 64-bit PC, issues four byte reads per instruction, assembles them little-endian into a 32-bit word, hands the word to decode over a valid/ready handshake, and applies branch redirects. It also detects the HALT encoding and stops fetching.

## Interface
- `PC_W`, 64: PC and memory address width.
- `RESET_PC`, 0: PC value loaded on reset.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `mem_req` out 1: byte read request.
- `mem_addr` out PC_W: byte address, equal to pc + byte index.
- `mem_ack` in 1: byte accepted; `mem_rdata` is valid in the same cycle.
- `mem_rdata` in 8: read byte.
- `inst_valid` out 1: `inst`/`inst_pc` hold a complete instruction.
- `inst_ready` in 1: decode accepts the instruction.
- `inst` out 32: assembled instruction.
- `inst_pc` out PC_W: address of `inst`.
- `branch_taken` in 1: redirect request for an already-accepted instruction.
- `branch_target` in PC_W: redirect address.
- `halted` out 1: HALT was consumed and fetch has stopped.

## Operation
- States: IDLE, FETCH, HOLD, HALT. Byte index `idx` is 2 bits.
- **IDLE** (reset state): on the next clock, go to FETCH with `idx`=0.
- **FETCH**:
  - `mem_req`=1 and `mem_addr`=pc+idx.
  - On `mem_req & mem_ack`, store `mem_rdata` in `inst[8*idx+7:8*idx]` and set `idx`+1.
  - When the byte with `idx`=3 is accepted, go to HOLD with `inst_valid`=1 and `inst_pc`=pc.
- **HOLD**:
  - `mem_req`=0.
  - Transfer happens when `inst_valid & inst_ready & ~branch_taken`.
  - On transfer: pc <= pc+4, `idx`=0, `inst_valid`=0, next state FETCH (or HALT, see below).
- **Branch redirect** (`branch_taken`=1 in IDLE/FETCH/HOLD):
  - pc <= `branch_target`, `idx`=0, `inst_valid`=0, next state FETCH.
  - Any partial bytes or held instruction is discarded.
  - The redirect has priority over transfer and over `mem_ack` in the same cycle; the acked byte is dropped.
- **HALT** (with macro): an instruction with `inst[31:21]`=11'h7FF is presented normally. On its transfer, enter HALT with `halted`=1 and `mem_req`=0. Only reset leaves HALT. `branch_taken` is ignored in HALT.
- **Arithmetic**:
  - pc+idx and pc+4 are PC_W-bit and wrap modulo 2^PC_W.
  - `branch_target` is used unmodified; no alignment check.
- **Reset mid-operation**: all state returns to reset values immediately (asynchronous). Partial instructions are lost.

## Timing
- **Reset values**:
  - `mem_req`=0, `mem_addr`=RESET_PC, `inst_valid`=0, `halted`=0.
  - `inst`=32'hD503201F (NOP), `inst_pc`=RESET_PC.
  - pc=RESET_PC, `idx`=0.
- `mem_req` and `mem_addr` are decoded from registered state only, with no combinational path from the inputs. `mem_addr` is stable while `mem_req`=1 and no ack has arrived.
- **Latency**:
  - With `mem_ack` held high, `inst_valid` rises 4 cycles after FETCH is entered.
  - First instruction after reset release: `inst_valid` high at the 5th rising edge.
- **Throughput**: with ack and ready always high, one instruction per 5 cycles (4 FETCH + 1 HOLD).
- `inst`, `inst_pc`, `inst_valid` are registered and hold steady in HOLD until transfer or redirect.
- A redirect takes effect at the next edge; new `mem_addr`=`branch_target` in the following cycle.

## Configuration
- `FETCH_HALT_DETECT_EN`:
  - Defined: HALT detection as described; `halted` and the HALT state are active.
  - Undefined: no opcode inspection. The HALT encoding is fetched and transferred like any other instruction, fetching continues at pc+4, and `halted` is tied to 0.

## Test plan
- **Reset**: assert `rst_n`=0 mid-FETCH -> all outputs at the reset values listed above. One cycle after release: `mem_req`=1, `mem_addr`=0.
- **Sequential fetch**: memory bytes 1F,20,03,D5 at 0..3 and 00,00,80,D2 at 4..7; ack and ready always 1 -> `inst`=D503201F with `inst_pc`=0, then D2800000 with `inst_pc`=4, spaced 5 cycles apart.
- **Backpressure and ack gaps**: `mem_ack` low for 3 cycles on byte 2 and `inst_ready` low for 4 cycles -> `mem_addr`=2 held for those cycles; `inst` unchanged until ready; pc advances by exactly 4.
- **Redirect mid-fetch and in HOLD**: `branch_taken`=1 with target 0x100 after 2 bytes -> next `mem_addr`=0x100, no `inst_valid` for the old word. Redirect in HOLD with `inst_ready`=1 -> no transfer, next `inst_pc`=0x100.
- **Wrap**: `branch_target`=2^64-4 -> addresses FFFF…FFFC..FFFF…FFFF, next pc=0.
- **HALT**: word FFE00000 -> with macro, `halted`=1 after transfer and `mem_req` stays 0 for ≥10 cycles despite `branch_taken`. Without macro, the word transfers and fetch continues at pc+4.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: byte-wide memory reads assembled into 32-bit words for decode.
// Optional HALT detection is enabled by defining FETCH_HALT_DETECT_EN.
module fetch_sequencer #(
  parameter int unsigned          PC_W     = 64,
  parameter logic [PC_W-1:0]      RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            mem_req,
  output logic [PC_W-1:0] mem_addr,
  input  logic            mem_ack,
  input  logic [7:0]      mem_rdata,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst,
  output logic [PC_W-1:0] inst_pc,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_target,
  output logic            halted
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, HALT} state_t;

  state_t          state;
  logic [PC_W-1:0] pc;
  logic [1:0]      idx;
  logic            xfer;

  // Memory port is decoded from registered state only.
  assign mem_req  = (state == FETCH);
  assign mem_addr = pc + PC_W'(idx);
  assign xfer     = inst_valid & inst_ready & ~branch_taken;

`ifdef FETCH_HALT_DETECT_EN
  logic is_halt;
  assign is_halt = (inst[31:21] == 11'h7FF);
`else
  assign halted = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      idx        <= '0;
      inst       <= 32'hD503_201F;
      inst_pc    <= RESET_PC;
      inst_valid <= 1'b0;
`ifdef FETCH_HALT_DETECT_EN
      halted     <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (branch_taken) pc <= branch_target;
          idx   <= '0;
          state <= FETCH;
        end
        FETCH: begin
          // Redirect wins over a same-cycle ack; the acked byte is dropped.
          if (branch_taken) begin
            pc  <= branch_target;
            idx <= '0;
          end else if (mem_ack) begin
            inst[{idx, 3'b000} +: 8] <= mem_rdata;
            idx <= idx + 2'd1;
            if (idx == 2'd3) begin
              state      <= HOLD;
              inst_valid <= 1'b1;
              inst_pc    <= pc;
            end
          end
        end
        HOLD: begin
          if (branch_taken) begin
            pc         <= branch_target;
            idx        <= '0;
            inst_valid <= 1'b0;
            state      <= FETCH;
          end else if (xfer) begin
            pc         <= pc + PC_W'(3'd4);
            idx        <= '0;
            inst_valid <= 1'b0;
`ifdef FETCH_HALT_DETECT_EN
            state      <= is_halt ? HALT : FETCH;
            halted     <= is_halt;
`else
            state      <= FETCH;
`endif
          end
        end
        HALT: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: scoreboard of expected transfers plus per-scenario checks.
module tb_fetch_sequencer;

  localparam int unsigned PC_W = 64;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            mem_req;
  logic [PC_W-1:0] mem_addr;
  logic            mem_ack = 1'b0;
  logic [7:0]      mem_rdata;
  logic            inst_valid;
  logic            inst_ready = 1'b0;
  logic [31:0]     inst;
  logic [PC_W-1:0] inst_pc;
  logic            branch_taken = 1'b0;
  logic [PC_W-1:0] branch_target = '0;
  logic            halted;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0]     inst;
    logic [PC_W-1:0] pc;
  } exp_t;
  exp_t sb[$];

  fetch_sequencer #(.PC_W(PC_W), .RESET_PC('0)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
    .branch_taken(branch_taken), .branch_target(branch_target), .halted(halted)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [PC_W-1:0] base);
    case (base)
      64'h0:   return 32'hD503_201F;
      64'h4:   return 32'hD280_0000;
      64'h200: return 32'hFFE0_0000;
      default: return base[31:0] ^ 32'h1234_5678;
    endcase
  endfunction

  function automatic logic [7:0] mem_byte(input logic [PC_W-1:0] a);
    logic [31:0] w;
    w = word_at({a[PC_W-1:2], 2'b00});
    return w[{a[1:0], 3'b000} +: 8];
  endfunction

  assign mem_rdata = mem_byte(mem_addr);

  // Scoreboard: every handshake decode sees is popped and compared here.
  always @(negedge clk) begin
    if (rst_n && inst_valid && inst_ready && !branch_taken) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL xfer_unexpected got inst=%h pc=%h required no transfer", inst, inst_pc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (inst !== e.inst || inst_pc !== e.pc) begin
          fails++;
          $display("FAIL xfer got inst=%h pc=%h required inst=%h pc=%h", inst, inst_pc, e.inst, e.pc);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [PC_W-1:0] p);
    exp_t e;
    e.inst = word_at(p);
    e.pc   = p;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; mem_ack = 1'b0; inst_ready = 1'b0; branch_taken = 1'b0; branch_target = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    sb.delete();
  endtask

  // Returns at a negedge with inst_valid high; n = clock edges taken.
  task automatic wait_valid(output int n);
    n = 0;
    @(negedge clk);
    while (!inst_valid && n < 20) begin
      step();
      n++;
      @(negedge clk);
    end
    tests++;
    if (!inst_valid) begin
      fails++;
      $display("FAIL wait_valid timeout got inst_valid=0 required 1");
    end
  endtask

  task automatic test_reset();
    do_reset();
    mem_ack = 1'b1; inst_ready = 1'b1;
    repeat (3) step();
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (mem_req !== 1'b0 || mem_addr !== 64'h0 || inst_valid !== 1'b0 || halted !== 1'b0 ||
        inst !== 32'hD503201F || inst_pc !== 64'h0) begin
      fails++;
      $display("FAIL reset_values got req=%b addr=%h v=%b h=%b inst=%h pc=%h required 0 0 0 0 d503201f 0",
               mem_req, mem_addr, inst_valid, halted, inst, inst_pc);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    step();
    @(negedge clk);
    tests++;
    if (mem_req !== 1'b1 || mem_addr !== 64'h0) begin
      fails++;
      $display("FAIL reset_release got req=%b addr=%h required req=1 addr=0", mem_req, mem_addr);
    end
  endtask

  task automatic test_sequential();
    int n;
    do_reset();
    mem_ack = 1'b1; inst_ready = 1'b1;
    push_exp(64'h0); push_exp(64'h4);
    wait_valid(n);
    tests++;
    if (n != 5) begin fails++; $display("FAIL first_latency got %0d required 5", n); end
    tests++;
    if (inst !== 32'hD503201F) begin fails++; $display("FAIL first_inst got %h required d503201f", inst); end
    step();
    wait_valid(n);
    tests++;
    if (n + 1 != 5) begin fails++; $display("FAIL throughput got %0d required 5", n + 1); end
    step();
    inst_ready = 1'b0;
    tests++;
    if (sb.size() != 0) begin fails++; $display("FAIL seq_leftover got %0d required 0", sb.size()); end
  endtask

  task automatic test_backpressure();
    do_reset();
    mem_ack = 1'b1; inst_ready = 1'b0;
    push_exp(64'h0);
    repeat (3) step();
    mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++;
      if (mem_req !== 1'b1 || mem_addr !== 64'h2) begin
        fails++;
        $display("FAIL ack_gap_addr got req=%b addr=%h required req=1 addr=2", mem_req, mem_addr);
      end
      step();
    end
    mem_ack = 1'b1;
    repeat (2) step();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tests++;
      if (inst_valid !== 1'b1 || inst !== 32'hD503201F || inst_pc !== 64'h0) begin
        fails++;
        $display("FAIL hold_steady got v=%b inst=%h pc=%h required v=1 inst=d503201f pc=0",
                 inst_valid, inst, inst_pc);
      end
      step();
    end
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    @(negedge clk);
    tests++;
    if (mem_addr !== 64'h4 || inst_valid !== 1'b0) begin
      fails++;
      $display("FAIL pc_advance got addr=%h v=%b required addr=4 v=0", mem_addr, inst_valid);
    end
    tests++;
    if (sb.size() != 0) begin fails++; $display("FAIL bp_leftover got %0d required 0", sb.size()); end
  endtask

  task automatic test_redirect();
    int n;
    do_reset();
    mem_ack = 1'b1; inst_ready = 1'b1;
    repeat (3) step();
    branch_taken = 1'b1; branch_target = 64'h100;
    step();
    branch_taken = 1'b0;
    @(negedge clk);
    tests++;
    if (mem_req !== 1'b1 || mem_addr !== 64'h100 || inst_valid !== 1'b0) begin
      fails++;
      $display("FAIL redirect_fetch got req=%b addr=%h v=%b required req=1 addr=100 v=0",
               mem_req, mem_addr, inst_valid);
    end
    step();
    wait_valid(n);
    branch_taken = 1'b1;
    step();
    branch_taken = 1'b0;
    @(negedge clk);
    tests++;
    if (inst_valid !== 1'b0 || mem_addr !== 64'h100) begin
      fails++;
      $display("FAIL redirect_hold got v=%b addr=%h required v=0 addr=100", inst_valid, mem_addr);
    end
    push_exp(64'h100);
    wait_valid(n);
    tests++;
    if (inst_pc !== 64'h100) begin fails++; $display("FAIL redirect_pc got %h required 100", inst_pc); end
    step();
    inst_ready = 1'b0;
    tests++;
    if (sb.size() != 0) begin fails++; $display("FAIL redir_leftover got %0d required 0", sb.size()); end
  endtask

  task automatic test_wrap();
    logic [PC_W-1:0] base;
    base = 64'hFFFF_FFFF_FFFF_FFFC;
    do_reset();
    mem_ack = 1'b1; inst_ready = 1'b1;
    step();
    branch_taken = 1'b1; branch_target = base;
    step();
    branch_taken = 1'b0;
    push_exp(base);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tests++;
      if (mem_addr !== base + 64'(i)) begin
        fails++;
        $display("FAIL wrap_addr got %h required %h", mem_addr, base + 64'(i));
      end
      step();
    end
    step();
    inst_ready = 1'b0;
    @(negedge clk);
    tests++;
    if (mem_addr !== 64'h0 || mem_req !== 1'b1) begin
      fails++;
      $display("FAIL wrap_pc got addr=%h req=%b required addr=0 req=1", mem_addr, mem_req);
    end
    tests++;
    if (sb.size() != 0) begin fails++; $display("FAIL wrap_leftover got %0d required 0", sb.size()); end
  endtask

  task automatic test_halt();
    int n;
    do_reset();
    mem_ack = 1'b1; inst_ready = 1'b1;
    branch_taken = 1'b1; branch_target = 64'h200;
    step();
    branch_taken = 1'b0;
    push_exp(64'h200);
    wait_valid(n);
    step();
`ifdef FETCH_HALT_DETECT_EN
    for (int i = 0; i < 12; i++) begin
      branch_taken = 1'b1; branch_target = 64'h0;
      @(negedge clk);
      tests++;
      if (mem_req !== 1'b0 || halted !== 1'b1) begin
        fails++;
        $display("FAIL halt_stop got req=%b halted=%b required req=0 halted=1", mem_req, halted);
      end
      step();
    end
    branch_taken = 1'b0;
`else
    inst_ready = 1'b0;
    @(negedge clk);
    tests++;
    if (mem_req !== 1'b1 || mem_addr !== 64'h204 || halted !== 1'b0) begin
      fails++;
      $display("FAIL halt_off got req=%b addr=%h halted=%b required req=1 addr=204 halted=0",
               mem_req, mem_addr, halted);
    end
`endif
    tests++;
    if (sb.size() != 0) begin fails++; $display("FAIL halt_leftover got %0d required 0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_halt();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
